// File: rtl/car_park_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_park_pkg
// Description : Shared types and sensor codes for the car-park occupancy
//               counter: FSM state encoding and the {a,b} beam patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package car_park_pkg;

  // Sequence tracker states; EN* walk the entry path, EX* the exit path.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN1   = 3'd1,
    EN2   = 3'd2,
    EN3   = 3'd3,
    EX1   = 3'd4,
    EX2   = 3'd5,
    EX3   = 3'd6,
    FAULT = 3'd7
  } state_t;

  // Synchronised beam pattern {outer, inner}.
  localparam logic [1:0] AB_CLEAR = 2'b00;
  localparam logic [1:0] AB_OUTER = 2'b10;
  localparam logic [1:0] AB_BOTH  = 2'b11;
  localparam logic [1:0] AB_INNER = 2'b01;

endpackage
`default_nettype wire

// File: rtl/sensor_sync.sv
`default_nettype none
// ============================================================================
// Module      : sensor_sync
// Description : Multi-flop synchroniser for asynchronous beam-sensor inputs.
//               Every stage clears on reset; latency is SYNC_STAGES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  // First stage captures the raw asynchronous input.
  assign sync_d[0] = din;

  // Remaining stages each take the previous stage's value.
  for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_stage
    assign sync_d[i] = sync_q[i-1];
  end

  // Shift the chain; reset empties it so stale beam states are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/car_park_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : car_park_occupancy
// Description : Decodes outer/inner beam sensors into entry/exit pulses and
//               keeps a saturating occupancy count with full/empty/fault
//               status and overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module car_park_occupancy
  import car_park_pkg::*;
#(
  parameter int COUNT_W     = 4,
  parameter int MAX_COUNT   = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic               enter,
  output logic               exit,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               fault,
  output logic               ovf,
  output logic               unf
);

  localparam logic [COUNT_W-1:0] C_MAX = COUNT_W'(MAX_COUNT);

  logic [1:0]         ab;
  state_t             state_q, state_d;
  logic               enter_q, enter_d;
  logic               exit_q, exit_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               fault_q, fault_d;
  logic [COUNT_W-1:0] count_q, count_d;

  sensor_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (2)
  ) u_sensor_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({a, b}),
    .dout  (ab)
  );

  // Register state, pulses, fault flag and count together so a pulse and
  // the count it caused become visible on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Track the beam pattern along the entry (10,11,01,00) or exit
  // (01,11,10,00) path; any jump that skips a step is a fault.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ab == AB_OUTER)      state_d = EN1;
        else if (ab == AB_INNER) state_d = EX1;
        else if (ab == AB_BOTH)  state_d = FAULT;
      end
      EN1: begin
        if (ab == AB_BOTH)       state_d = EN2;
        else if (ab == AB_CLEAR) state_d = IDLE;
        else if (ab == AB_INNER) state_d = FAULT;
      end
      EN2: begin
        if (ab == AB_INNER)      state_d = EN3;
        else if (ab == AB_OUTER) state_d = EN1;
        else if (ab == AB_CLEAR) state_d = FAULT;
      end
      EN3: begin
        if (ab == AB_BOTH)       state_d = EN2;
        else if (ab == AB_OUTER) state_d = FAULT;
        else if (ab == AB_CLEAR) begin
          state_d = IDLE;
          enter_d = 1'b1;
        end
      end
      EX1: begin
        if (ab == AB_BOTH)       state_d = EX2;
        else if (ab == AB_CLEAR) state_d = IDLE;
        else if (ab == AB_OUTER) state_d = FAULT;
      end
      EX2: begin
        if (ab == AB_OUTER)      state_d = EX3;
        else if (ab == AB_INNER) state_d = EX1;
        else if (ab == AB_CLEAR) state_d = FAULT;
      end
      EX3: begin
        if (ab == AB_BOTH)       state_d = EX2;
        else if (ab == AB_INNER) state_d = FAULT;
        else if (ab == AB_CLEAR) begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end
      end
      FAULT: begin
        if (ab == AB_CLEAR)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fault_d = (state_d == FAULT);
  end

  // Saturating counter: pulses still fire at the limits, flagged by ovf/unf.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (enter_d) begin
      if (count_q == C_MAX) ovf_d   = 1'b1;
      else                  count_d = count_q + COUNT_W'(1);
    end
    if (exit_d) begin
      if (count_q == '0)    unf_d   = 1'b1;
      else                  count_d = count_q - COUNT_W'(1);
    end
  end

  assign enter = enter_q;
  assign exit  = exit_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign fault = fault_q;
  assign count = count_q;
  assign full  = (count_q == C_MAX);
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_car_park_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_park_occupancy
// Description : Self-checking bench for car_park_occupancy: directed
//               scenarios plus randomized beam traffic against a path-walk
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_park_occupancy;

  localparam int COUNT_W = 4;
  localparam int MAXC    = 15;
  localparam int S       = 2;

  // Beam patterns along each legal path, index 0 and 4 both "clear".
  localparam logic [1:0] P_EN [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] P_EX [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

  typedef enum int {M_IDLE, M_ENTRY, M_EXIT, M_FAULT} mmode_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic enter_o, exit_o, full_o, empty_o, fault_o, ovf_o, unf_o;
  logic [COUNT_W-1:0] count_o;

  car_park_occupancy #(
    .COUNT_W     (COUNT_W),
    .MAX_COUNT   (MAXC),
    .SYNC_STAGES (S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .enter (enter_o),
    .exit  (exit_o),
    .count (count_o),
    .full  (full_o),
    .empty (empty_o),
    .fault (fault_o),
    .ovf   (ovf_o),
    .unf   (unf_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [1:0] hist [$];
  mmode_t     mode;
  int         pos;
  int         m_count;
  logic       m_enter, m_exit, m_ovf, m_unf;

  // Observation accumulators (DUT side and model side).
  int o_en, o_ex, o_ovf, o_unf, o_fault_cyc;
  int m_en, m_ex;
  int en_cnt_at, en_prev_at, ex_cnt_at, ex_prev_at;
  int ovf_with_en, unf_with_ex;
  int prev_count;
  int n_diff, first_diff, cyc;

  task automatic clear_obs();
    o_en = 0; o_ex = 0; o_ovf = 0; o_unf = 0; o_fault_cyc = 0;
    m_en = 0; m_ex = 0;
    en_cnt_at = -1; en_prev_at = -1; ex_cnt_at = -1; ex_prev_at = -1;
    ovf_with_en = 0; unf_with_ex = 0;
    n_diff = 0; first_diff = -1;
  endtask

  task automatic model_edge(input logic [1:0] s);
    logic [1:0] cur, nxt, prv;
    case (mode)
      M_IDLE: begin
        if (s == P_EN[1])      begin mode = M_ENTRY; pos = 1; end
        else if (s == P_EX[1]) begin mode = M_EXIT;  pos = 1; end
        else if (s != 2'b00)   mode = M_FAULT;
      end
      M_ENTRY, M_EXIT: begin
        cur = (mode == M_ENTRY) ? P_EN[pos]   : P_EX[pos];
        nxt = (mode == M_ENTRY) ? P_EN[pos+1] : P_EX[pos+1];
        prv = (mode == M_ENTRY) ? P_EN[pos-1] : P_EX[pos-1];
        if (s == cur) begin
        end else if (s == nxt) begin
          pos++;
          if (pos == 4) begin
            if (mode == M_ENTRY) begin
              m_enter = 1'b1;
              if (m_count == MAXC) m_ovf = 1'b1; else m_count++;
            end else begin
              m_exit = 1'b1;
              if (m_count == 0) m_unf = 1'b1; else m_count--;
            end
            mode = M_IDLE; pos = 0;
          end
        end else if (s == prv) begin
          pos--;
          if (pos == 0) mode = M_IDLE;
        end else begin
          mode = M_FAULT;
        end
      end
      default: if (s == 2'b00) mode = M_IDLE;
    endcase
  endtask

  // One clock: drive {a,b}, advance the model, then observe after the edge.
  task automatic step(input logic [1:0] v);
    logic [1:0] s;
    logic [COUNT_W-1:0] m_cnt_v;
    logic m_fault, m_full, m_empty;
    @(negedge clk);
    {a, b} = v;
    prev_count = int'(count_o);
    m_enter = 1'b0; m_exit = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    if (reset) begin
      hist = {};
      repeat (S) hist.push_back(2'b00);
      mode = M_IDLE; pos = 0; m_count = 0;
    end else begin
      hist.push_back(v);
      s = hist.pop_front();
      model_edge(s);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (enter_o) begin o_en++; en_cnt_at = int'(count_o); en_prev_at = prev_count; if (ovf_o) ovf_with_en++; end
    if (exit_o)  begin o_ex++; ex_cnt_at = int'(count_o); ex_prev_at = prev_count; if (unf_o) unf_with_ex++; end
    if (ovf_o) o_ovf++;
    if (unf_o) o_unf++;
    if (fault_o) o_fault_cyc++;
    if (m_enter) m_en++;
    if (m_exit)  m_ex++;
    m_cnt_v = COUNT_W'(m_count);
    m_fault = (mode == M_FAULT);
    m_full  = (m_count == MAXC);
    m_empty = (m_count == 0);
    if ({enter_o, exit_o, ovf_o, unf_o, fault_o, full_o, empty_o, count_o} !==
        {m_enter, m_exit, m_ovf, m_unf, m_fault, m_full, m_empty, m_cnt_v}) begin
      if (n_diff == 0) first_diff = cyc;
      n_diff++;
    end
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    repeat (n) step(v);
  endtask

  task automatic do_reset(input logic [1:0] v);
    reset = 1'b1;
    step(v);
    reset = 1'b0;
  endtask

  task automatic do_entry();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, S + 2);
  endtask

  task automatic do_exit();
    hold(2'b01, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, S + 2);
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_cmp++; if ({empty_o, full_o} !== 2'b10) begin n_err++; $display("FAIL reset_empty_full: got %b want 10", {empty_o, full_o}); end
    n_cmp++; if ({enter_o, exit_o, ovf_o, unf_o, fault_o} !== 5'b0) begin n_err++; $display("FAIL reset_pulses: got %b want 00000", {enter_o, exit_o, ovf_o, unf_o, fault_o}); end
  endtask

  task automatic test_entry();
    do_reset(2'b00);
    clear_obs();
    do_entry();
    n_cmp++; if (o_en !== 1) begin n_err++; $display("FAIL entry_pulses: got %0d want 1", o_en); end
    n_cmp++; if (o_ex !== 0) begin n_err++; $display("FAIL entry_no_exit: got %0d want 0", o_ex); end
    n_cmp++; if (en_cnt_at !== 1 || en_prev_at !== 0) begin n_err++; $display("FAIL entry_count_with_pulse: got %0d->%0d want 0->1", en_prev_at, en_cnt_at); end
    n_cmp++; if ({count_o, empty_o} !== {4'd1, 1'b0}) begin n_err++; $display("FAIL entry_final: got count %0d empty %b want 1 0", count_o, empty_o); end
  endtask

  task automatic test_exit();
    do_reset(2'b00);
    do_entry(); do_entry();
    clear_obs();
    do_exit();
    n_cmp++; if (o_ex !== 1 || o_en !== 0) begin n_err++; $display("FAIL exit_pulses: got exit %0d enter %0d want 1 0", o_ex, o_en); end
    n_cmp++; if (ex_cnt_at !== 1 || ex_prev_at !== 2) begin n_err++; $display("FAIL exit_count_with_pulse: got %0d->%0d want 2->1", ex_prev_at, ex_cnt_at); end
  endtask

  task automatic test_aborts();
    do_reset(2'b00);
    clear_obs();
    hold(2'b10, 3); hold(2'b00, S + 3);
    n_cmp++; if (o_en + o_ex + o_fault_cyc !== 0 || count_o !== 4'd0) begin n_err++; $display("FAIL abort_quiet: got pulses %0d fault %0d count %0d want 0 0 0", o_en + o_ex, o_fault_cyc, count_o); end
    do_entry();
    n_cmp++; if (o_en !== 1 || count_o !== 4'd1) begin n_err++; $display("FAIL abort_then_entry: got enter %0d count %0d want 1 1", o_en, count_o); end
    clear_obs();
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b11, 2); hold(2'b01, 2); hold(2'b00, S + 2);
    n_cmp++; if (o_en !== 1 || o_ex !== 0 || count_o !== 4'd2) begin n_err++; $display("FAIL backoff: got enter %0d exit %0d count %0d want 1 0 2", o_en, o_ex, count_o); end
  endtask

  task automatic test_fault();
    do_reset(2'b00);
    do_entry();
    clear_obs();
    for (int i = 1; i <= S + 1; i++) begin
      step(2'b11);
      if (i == S) begin
        n_cmp++; if (fault_o !== 1'b0) begin n_err++; $display("FAIL fault_early: got %b want 0", fault_o); end
      end
    end
    n_cmp++; if (fault_o !== 1'b1) begin n_err++; $display("FAIL fault_set: got %b want 1", fault_o); end
    hold(2'b11, 4);
    n_cmp++; if (fault_o !== 1'b1) begin n_err++; $display("FAIL fault_hold: got %b want 1", fault_o); end
    hold(2'b00, S);
    n_cmp++; if (fault_o !== 1'b1) begin n_err++; $display("FAIL fault_before_clear: got %b want 1", fault_o); end
    step(2'b00);
    n_cmp++; if (fault_o !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %b want 0", fault_o); end
    n_cmp++; if (o_en + o_ex !== 0 || count_o !== 4'd1) begin n_err++; $display("FAIL fault_side_effects: got pulses %0d count %0d want 0 1", o_en + o_ex, count_o); end
  endtask

  task automatic test_saturation();
    do_reset(2'b00);
    repeat (MAXC) do_entry();
    n_cmp++; if ({count_o, full_o} !== {4'd15, 1'b1}) begin n_err++; $display("FAIL sat_full: got count %0d full %b want 15 1", count_o, full_o); end
    clear_obs();
    do_entry();
    n_cmp++; if (o_en !== 1 || ovf_with_en !== 1 || o_ovf !== 1) begin n_err++; $display("FAIL sat_ovf: got enter %0d ovf_with %0d ovf %0d want 1 1 1", o_en, ovf_with_en, o_ovf); end
    n_cmp++; if (count_o !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", count_o); end
    do_reset(2'b00);
    clear_obs();
    do_exit();
    n_cmp++; if (o_ex !== 1 || unf_with_ex !== 1 || o_unf !== 1) begin n_err++; $display("FAIL sat_unf: got exit %0d unf_with %0d unf %0d want 1 1 1", o_ex, unf_with_ex, o_unf); end
    n_cmp++; if ({count_o, empty_o} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL sat_empty: got count %0d empty %b want 0 1", count_o, empty_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(2'b00);
    clear_obs();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3 + S);
    do_reset(2'b01);
    hold(2'b00, S + 4);
    n_cmp++; if (o_en !== 0 || count_o !== 4'd0 || fault_o !== 1'b0) begin n_err++; $display("FAIL reset_mid: got enter %0d count %0d fault %b want 0 0 0", o_en, count_o, fault_o); end
    do_entry();
    n_cmp++; if (o_en !== 1 || count_o !== 4'd1) begin n_err++; $display("FAIL reset_mid_idle: got enter %0d count %0d want 1 1", o_en, count_o); end
  endtask

  task automatic test_random();
    logic [1:0] seq [$];
    int kind;
    do_reset(2'b00);
    clear_obs();
    for (int e = 0; e < 120; e++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1:    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        2:       seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        3:       seq = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00};
        4:       seq = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
        5:       seq = '{2'b01, 2'b00};
        6:       seq = '{2'b10, 2'b00};
        default: begin
          seq = {};
          repeat (3) seq.push_back(2'($urandom));
          seq.push_back(2'b00);
        end
      endcase
      foreach (seq[i]) hold(seq[i], int'($urandom_range(1, 3)));
    end
    hold(2'b00, S + 2);
    n_cmp++; if (n_diff !== 0) begin n_err++; $display("FAIL random_cycles: got %0d differing cycles (first at %0d) want 0", n_diff, first_diff); end
    n_cmp++; if (o_en !== m_en || o_ex !== m_ex) begin n_err++; $display("FAIL random_pulse_totals: got %0d/%0d want %0d/%0d", o_en, o_ex, m_en, m_ex); end
    n_cmp++; if (int'(count_o) !== m_count) begin n_err++; $display("FAIL random_count: got %0d want %0d", count_o, m_count); end
  endtask

  initial begin
    cyc = 0;
    mode = M_IDLE; pos = 0; m_count = 0;
    clear_obs();
    test_reset();
    test_entry();
    test_exit();
    test_aborts();
    test_fault();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
